// File: rtl/qr_arith_pkg.sv
// Shared arithmetic definitions for the QR datapath: default widths, pipeline
// depth limits and the fixed-point round/saturate helper used by post-stages.
package qr_arith_pkg;

  localparam int DEF_W      = 16;
  localparam int STAGES_MIN = 2;
  localparam int STAGES_MAX = 6;
  // Working width for round_sat: holds any product up to 64 bits plus headroom.
  localparam int RS_W       = 66;
  localparam logic signed [RS_W-1:0] RS_ONE = {{(RS_W-1){1'b0}}, 1'b1};

  // Round half-up by frac bits, then clamp to out_w; returns {sat, res}.
  // value must already be sign- or zero-extended to RS_W according to tc.
  function automatic logic [RS_W:0] round_sat(input logic [RS_W-1:0] value,
                                              input logic            tc,
                                              input int              frac,
                                              input int              out_w);
    logic signed [RS_W-1:0] v_s;
    logic signed [RS_W-1:0] half_s;
    logic signed [RS_W-1:0] r_s;
    logic signed [RS_W-1:0] hi_s;
    logic signed [RS_W-1:0] lo_s;
    logic signed [RS_W-1:0] res_s;
    logic                   sat_s;
    v_s = signed'(value);
    if (frac > 0) begin
      half_s = RS_ONE <<< (frac - 1);
    end else begin
      half_s = '0;
    end
    if (tc) begin
      r_s  = (v_s + half_s) >>> frac;
      hi_s = (RS_ONE <<< (out_w - 1)) - RS_ONE;
      lo_s = -(RS_ONE <<< (out_w - 1));
    end else begin
      r_s  = (v_s + half_s) >> frac;
      hi_s = (RS_ONE <<< out_w) - RS_ONE;
      lo_s = '0;
    end
    if (r_s > hi_s) begin
      res_s = hi_s;
      sat_s = 1'b1;
    end else if (r_s < lo_s) begin
      res_s = lo_s;
      sat_s = 1'b1;
    end else begin
      res_s = r_s;
      sat_s = 1'b0;
    end
    return {sat_s, res_s};
  endfunction

endpackage

// File: rtl/mult_pipe_rs_if.sv
// Operand/result handshake bundle for mult_pipe_rs; slave is the multiplier side.
interface mult_pipe_rs_if #(
  parameter int A_W   = qr_arith_pkg::DEF_W,
  parameter int B_W   = qr_arith_pkg::DEF_W,
  parameter int OUT_W = qr_arith_pkg::DEF_W
) ();
  logic                 i_valid;
  logic                 o_ready;
  logic [A_W-1:0]       i_a;
  logic [B_W-1:0]       i_b;
  logic                 i_tc;
  logic                 i_flush;
  logic                 o_valid;
  logic                 i_ready;
  logic [A_W+B_W-1:0]   o_prod;
  logic [OUT_W-1:0]     o_res;
  logic                 o_sat;

  modport slave (
    input  i_valid, i_a, i_b, i_tc, i_flush, i_ready,
    output o_ready, o_valid, o_prod, o_res, o_sat
  );

  modport master (
    output i_valid, i_a, i_b, i_tc, i_flush, i_ready,
    input  o_ready, o_valid, o_prod, o_res, o_sat
  );
endinterface

// File: rtl/pipe_delay_reg.sv
// Enable-gated shift register with a parallel valid-clear; all taps advance together.
module pipe_delay_reg #(
  parameter int W     = 8,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] din,
  input  logic         din_valid,
  output logic [W-1:0] dout,
  output logic         dout_valid
);
  logic [W-1:0]     data_r [DEPTH];
  logic [DEPTH-1:0] valid_r;

  // Valid chain: clear wins over enable so killed slots never re-emerge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= '0;
    end else if (clr) begin
      valid_r <= '0;
    end else if (en) begin
      valid_r[0] <= din_valid;
      for (int i = 1; i < DEPTH; i++) begin
        valid_r[i] <= valid_r[i-1];
      end
    end
  end

  // Data chain shifts on enable only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_r[i] <= '0;
      end
    end else if (en) begin
      data_r[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        data_r[i] <= data_r[i-1];
      end
    end
  end

  assign dout       = data_r[DEPTH-1];
  assign dout_valid = valid_r[DEPTH-1];
endmodule

// File: rtl/mult_pipe_rs.sv
// Pipelined signed/unsigned multiplier with lock-step valid/ready flow control
// and a registered fixed-point round-and-saturate output stage.
module mult_pipe_rs
  import qr_arith_pkg::*;
#(
  parameter int A_W    = DEF_W,
  parameter int B_W    = DEF_W,
  parameter int STAGES = 2,
  parameter int FRAC   = 0,
  parameter int OUT_W  = DEF_W
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  mult_pipe_rs_if.slave bus
);
  localparam int P_W = A_W + B_W;
  localparam int DLY = ((STAGES > STAGES_MAX) ? STAGES_MAX : STAGES) - STAGES_MIN;

  logic             adv_s;
  logic [P_W-1:0]   a_ext_s;
  logic [P_W-1:0]   b_ext_s;
  logic [P_W-1:0]   mul_s;
  logic [P_W-1:0]   s1_prod_r;
  logic             s1_tc_r;
  logic             s1_valid_r;
  logic [P_W-1:0]   dl_prod_s;
  logic             dl_tc_s;
  logic             dl_valid_s;
  logic [RS_W-1:0]  rs_in_s;
  logic [OUT_W-1:0] rs_res_s;
  logic             rs_sat_s;
  logic             o_valid_r;
  logic             o_sat_r;
  logic [P_W-1:0]   o_prod_r;
  logic [OUT_W-1:0] o_res_r;

  // Whole pipeline moves as one; a full output slot blocks only when not consumed.
  assign adv_s       = ~o_valid_r | bus.i_ready;
  assign bus.o_ready = adv_s;
  assign bus.o_valid = o_valid_r;
  assign bus.o_prod  = o_prod_r;
  assign bus.o_res   = o_res_r;
  assign bus.o_sat   = o_sat_r;

  // Extending by mode lets one P_W-bit modular multiply serve both signednesses.
  always_comb begin
    if (bus.i_tc) begin
      a_ext_s = {{B_W{bus.i_a[A_W-1]}}, bus.i_a};
      b_ext_s = {{A_W{bus.i_b[B_W-1]}}, bus.i_b};
    end else begin
      a_ext_s = {{B_W{1'b0}}, bus.i_a};
      b_ext_s = {{A_W{1'b0}}, bus.i_b};
    end
    mul_s = a_ext_s * b_ext_s;
  end

  // Stage 1: register the full product and its mode bit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid_r <= 1'b0;
      s1_tc_r    <= 1'b0;
      s1_prod_r  <= '0;
    end else if (bus.i_flush) begin
      s1_valid_r <= 1'b0;
    end else if (adv_s) begin
      s1_valid_r <= bus.i_valid;
      s1_tc_r    <= bus.i_tc;
      s1_prod_r  <= mul_s;
    end
  end

  generate
    if (DLY > 0) begin : g_dly
      logic [P_W:0] dl_dout_s;
      pipe_delay_reg #(.W(P_W + 1), .DEPTH(DLY)) u_dly (
        .clk        (i_clk),
        .rst_n      (i_rst_n),
        .en         (adv_s),
        .clr        (bus.i_flush),
        .din        ({s1_tc_r, s1_prod_r}),
        .din_valid  (s1_valid_r),
        .dout       (dl_dout_s),
        .dout_valid (dl_valid_s)
      );
      assign {dl_tc_s, dl_prod_s} = dl_dout_s;
    end else begin : g_nodly
      assign dl_prod_s  = s1_prod_r;
      assign dl_tc_s    = s1_tc_r;
      assign dl_valid_s = s1_valid_r;
    end
  endgenerate

  // Widen by mode so the rounding add and shift follow the operand signedness.
  always_comb begin
    if (dl_tc_s) begin
      rs_in_s = {{(RS_W-P_W){dl_prod_s[P_W-1]}}, dl_prod_s};
    end else begin
      rs_in_s = {{(RS_W-P_W){1'b0}}, dl_prod_s};
    end
    rs_res_s = OUT_W'(round_sat(rs_in_s, dl_tc_s, FRAC, OUT_W));
    rs_sat_s = 1'(round_sat(rs_in_s, dl_tc_s, FRAC, OUT_W) >> RS_W);
  end

  // Output stage: holds while back-pressured; flush kills only the valid bit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid_r <= 1'b0;
      o_sat_r   <= 1'b0;
      o_prod_r  <= '0;
      o_res_r   <= '0;
    end else if (bus.i_flush) begin
      o_valid_r <= 1'b0;
    end else if (adv_s) begin
      o_valid_r <= dl_valid_s;
      o_prod_r  <= dl_prod_s;
      o_res_r   <= rs_res_s;
      o_sat_r   <= rs_sat_s;
    end
  end
endmodule
